// File: rtl/inv_bus_receiver.sv
// ---------------------------------------------------------------------------
// inv_bus_receiver
//
// Receiving end of the active-low (inverted) parallel data bus. A word is
// sampled on the rising Clock edge while Strobe_n is low and the receiver has
// room. It is stored with its polarity restored in a two-entry skid FIFO and
// presented downstream with a Valid/Accept handshake.
//
// Handshake semantics (both sides):
//   Upstream  : a word transfers on a rising edge where Strobe_n=0 and
//               BusReady=1. With BusReady=0 the bus driver holds the word
//               until it is taken, so a refused word is neither lost nor an
//               error.
//   Downstream: the head word transfers on a rising edge where Valid=1 and
//               Accept=1. Accept is ignored while Valid=0.
//   BusReady and Valid come from the registered occupancy count only, so
//   there is no combinational path from Accept or BusIn_n to any output.
//
// Ports:
//   Clock        in   rising-edge clock
//   Reset_n      in   asynchronous reset, active low
//   BusIn_n      in   [NrOfBits] inverted data word from the bus
//   Strobe_n     in   active-low word-present strobe
//   BusParity_n  in   inverted even-parity bit accompanying BusIn_n
//   BusReady     out  receiver can take a word this cycle
//   Result       out  [NrOfBits] true-polarity head word
//   Valid        out  Result holds a valid word
//   Accept       in   downstream consumes the head word when Valid=1
//   ClearErr     in   synchronous clear of ParityErr
//   ParityErr    out  sticky parity-error flag
//
// Configuration macro:
//   INV_BUS_PARITY_EN - when defined, every captured word is checked against
//                       BusParity_n and a mismatch sets the sticky ParityErr.
//                       When undefined, BusParity_n and ClearErr are ignored
//                       and ParityErr is tied low.
// ---------------------------------------------------------------------------
module inv_bus_receiver #(
    parameter int NrOfBits = 8
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [NrOfBits-1:0] BusIn_n,
    input  logic                Strobe_n,
    input  logic                BusParity_n,
    output logic                BusReady,
    output logic [NrOfBits-1:0] Result,
    output logic                Valid,
    input  logic                Accept,
    input  logic                ClearErr,
    output logic                ParityErr
);

    localparam logic [1:0] COUNT_EMPTY = 2'd0;
    localparam logic [1:0] COUNT_FULL  = 2'd2;

    logic [NrOfBits-1:0] slot_q [2];
    logic                rd_ptr_q;
    logic                wr_ptr_q;
    logic [1:0]          count_q;
    logic [1:0]          count_d;
    logic                push;
    logic                pop;

    assign BusReady = (count_q != COUNT_FULL);
    assign Valid    = (count_q != COUNT_EMPTY);
    assign Result   = slot_q[rd_ptr_q];

    assign push = ~Strobe_n & BusReady;
    assign pop  = Valid & Accept;

    // Simultaneous push and pop leaves the occupancy unchanged; at Count=2
    // push is already blocked by BusReady, so only a pop can happen there.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= COUNT_EMPTY;
        end else begin
            if (push) begin
                slot_q[wr_ptr_q] <= ~BusIn_n;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

`ifdef INV_BUS_PARITY_EN
    logic parity_err_q;
    logic parity_err_d;
    logic word_err;

    // Even parity of the true data must equal the true parity bit; any
    // difference is an error. The word is stored regardless.
    assign word_err = (^(~BusIn_n)) ^ (~BusParity_n);

    // A fresh error on the same edge as ClearErr takes priority.
    always_comb begin
        parity_err_d = parity_err_q;
        if (ClearErr) begin
            parity_err_d = 1'b0;
        end
        if (push && word_err) begin
            parity_err_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign ParityErr = parity_err_q;
`else
    // Parity inputs have no function in this build.
    logic unused_parity_inputs;
    assign unused_parity_inputs = BusParity_n ^ ClearErr;
    assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_inv_bus_receiver.sv
// ---------------------------------------------------------------------------
// Testbench for inv_bus_receiver (NrOfBits = 8).
// Inputs are driven 1 ns after the rising edge; outputs are checked 1 ns after
// the rising edge that should have produced them.
// ---------------------------------------------------------------------------
module tb_inv_bus_receiver;

    localparam int W = 8;
`ifdef INV_BUS_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [W-1:0] bus_n;
    logic         strobe_n;
    logic         parity_n;
    logic         bus_ready;
    logic [W-1:0] result;
    logic         valid;
    logic         accept;
    logic         clear_err;
    logic         parity_err;

    int n_total;
    int n_pass;

    inv_bus_receiver #(.NrOfBits(W)) dut (
        .Clock       (clk),
        .Reset_n     (rst_n),
        .BusIn_n     (bus_n),
        .Strobe_n    (strobe_n),
        .BusParity_n (parity_n),
        .BusReady    (bus_ready),
        .Result      (result),
        .Valid       (valid),
        .Accept      (accept),
        .ClearErr    (clear_err),
        .ParityErr   (parity_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         strobe_n;
        logic [W-1:0] bus_n;
        logic         accept;
        logic         exp_valid;
        logic         exp_ready;
        logic         chk_res;
        logic [W-1:0] exp_res;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s_n, input logic [W-1:0] b_n, input logic acc,
                                input logic ev, input logic er, input logic cr,
                                input logic [W-1:0] eres);
        vec_t v;
        v.strobe_n  = s_n;
        v.bus_n     = b_n;
        v.accept    = acc;
        v.exp_valid = ev;
        v.exp_ready = er;
        v.chk_res   = cr;
        v.exp_res   = eres;
        vecs.push_back(v);
    endfunction

    // ---------------- reference model ----------------
    logic [W-1:0] mq[$];
    logic         m_perr;

    task automatic model_edge(input logic s_n, input logic [W-1:0] b_n, input logic acc,
                              input logic p_n, input logic clr);
        logic         can_take;
        logic         has_word;
        logic [W-1:0] word;
        int           ones;
        can_take = (mq.size() < 2);
        has_word = (mq.size() > 0);
        if (has_word && acc) void'(mq.pop_front());
        if (!s_n && can_take) begin
            word = ~b_n;
            mq.push_back(word);
            if (clr) m_perr = 1'b0;
            if (PAR_EN) begin
                ones = 0;
                for (int k = 0; k < W; k++) ones += int'(word[k]);
                // even parity bit = number of ones mod 2
                if ((ones % 2) != int'(~p_n)) m_perr = 1'b1;
            end
        end else if (clr) begin
            m_perr = 1'b0;
        end
    endtask

    // ---------------- main test ----------------
    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        bus_n     = '1;
        strobe_n  = 1'b1;
        parity_n  = 1'b1;
        accept    = 1'b0;
        clear_err = 1'b0;

        // Table: single word, fill/backpressure, accept at empty, streaming.
        add(1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5);
        add(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        add(1'b0, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01);
        add(1'b0, 8'hFD, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
        add(1'b0, 8'hFC, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
        add(1'b1, 8'hFC, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02);
        add(1'b1, 8'hFC, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        add(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++)
            add(1'b0, 8'hFF - 8'(i), 1'b1, 1'b1, 1'b1, 1'b1, 8'(i));
        add(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        step();
        step();
        check("reset_hold_valid", valid, 1'b0);
        check("reset_hold_ready", bus_ready, 1'b1);
        rst_n = 1'b1;
        step();
        check("reset_valid", valid, 1'b0);
        check("reset_ready", bus_ready, 1'b1);
        check("reset_result", result, 8'h00);
        check("reset_perr", parity_err, 1'b0);

        foreach (vecs[i]) begin
            strobe_n = vecs[i].strobe_n;
            bus_n    = vecs[i].bus_n;
            accept   = vecs[i].accept;
            step();
            check($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_ready", i), bus_ready, vecs[i].exp_ready);
            if (vecs[i].chk_res)
                check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
        end

        // Parity sequence (flag stays 0 when the feature is compiled out).
        strobe_n = 1'b0; bus_n = 8'hFE; parity_n = 1'b1; accept = 1'b0; clear_err = 1'b0;
        step();
        check("par_err_set", parity_err, PAR_EN);
        strobe_n = 1'b1; accept = 1'b1;
        step();
        check("par_err_sticky", parity_err, PAR_EN);
        clear_err = 1'b1;
        step();
        check("par_err_clear", parity_err, 1'b0);
        strobe_n = 1'b0; bus_n = 8'hFE; parity_n = 1'b1;
        step();
        check("par_err_wins_clear", parity_err, PAR_EN);
        bus_n = 8'hFC; parity_n = 1'b1;
        step();
        check("par_good_even_clear", parity_err, 1'b0);
        check("par_good_even_res", result, 8'h03);
        clear_err = 1'b0; bus_n = 8'hFE; parity_n = 1'b0;
        step();
        check("par_good_odd", parity_err, 1'b0);
        check("par_good_odd_res", result, 8'h01);
        strobe_n = 1'b1;
        step();
        check("par_drain_valid", valid, 1'b0);

        // Reset mid-operation with an in-flight strobe.
        accept = 1'b0; strobe_n = 1'b0; bus_n = 8'h11;
        step();
        bus_n = 8'h22;
        step();
        check("full_ready", bus_ready, 1'b0);
        check("full_valid", valid, 1'b1);
        bus_n = 8'h33;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", valid, 1'b0);
        check("async_rst_ready", bus_ready, 1'b1);
        check("async_rst_result", result, 8'h00);
        check("async_rst_perr", parity_err, 1'b0);
        step();
        check("rst_edge_no_capture", valid, 1'b0);
        rst_n = 1'b1; strobe_n = 1'b0; bus_n = 8'h00;
        step();
        check("post_rst_valid", valid, 1'b1);
        check("post_rst_result", result, 8'hFF);
        // Changing the bus before the next edge must not reach Result.
        bus_n = 8'h55;
        #1;
        check("no_comb_path", result, 8'hFF);
        strobe_n = 1'b1; accept = 1'b1;
        step();
        check("post_rst_drain", valid, 1'b0);

        // Randomized phase against the queue model (DUT empty, flag clear).
        mq.delete();
        m_perr = 1'b0;
        for (int c = 0; c < 400; c++) begin
            strobe_n  = ($urandom_range(0, 3) == 0);
            bus_n     = W'($urandom);
            accept    = ($urandom_range(0, 2) != 0);
            parity_n  = 1'($urandom);
            clear_err = ($urandom_range(0, 7) == 0);
            model_edge(strobe_n, bus_n, accept, parity_n, clear_err);
            step();
            check("rand_valid", valid, mq.size() > 0);
            check("rand_ready", bus_ready, mq.size() < 2);
            check("rand_perr", parity_err, m_perr);
            if (mq.size() > 0) check("rand_result", result, mq[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
